// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - Pong match controller: serve/play/point sequencing, scoring and winner.
// Frame counters advance on the last visible pixel of each frame supplied by the VGA timing block.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic       clk_in,
  input  logic       i_rst,
  input  logic [9:0] o_x,
  input  logic [8:0] o_y,
  input  logic       btn_start,
  input  logic       pointPlayer1,
  input  logic       pointPlayer2,
  output logic       ball_rst,
  output logic       ball_enable,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_CNT = 8'(POINT_FRAMES);
  localparam logic [3:0] WIN_CNT   = 4'(WIN_SCORE);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic       ball_rst_q, ball_rst_d;
  logic       ball_en_q, ball_en_d;
  logic       btn_s1_q, btn_s2_q, btn_prev_q;
  logic       p1_q, p1_prev_q, p2_q, p2_prev_q;

  logic frame_tick, start_evt, pt1_evt, pt2_evt;

  assign frame_tick = (o_x == 10'd639) && (o_y == 9'd479);
  assign start_evt  = btn_s2_q & ~btn_prev_q;
  assign pt1_evt    = p1_q & ~p1_prev_q;
  assign pt2_evt    = p2_q & ~p2_prev_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    score1_d   = score1_q;
    score2_d   = score2_q;
    winner_d   = winner_q;
    ball_rst_d = 1'b0;
    ball_en_d  = (state_q == S_PLAY);

    if (state_q > S_GAMEOVER) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end else if (start_evt) begin
      state_d    = S_SERVE;
      cnt_d      = SERVE_CNT;
      score1_d   = 4'd0;
      score2_d   = 4'd0;
      winner_d   = 2'b00;
      ball_rst_d = 1'b1;
    end else begin
      case (state_q)
        S_SERVE: begin
          // Leaving on the tick that would bring the count to zero gives exactly SERVE_FRAMES ticks.
          if (frame_tick) begin
            if (cnt_q <= 8'd1) begin
              state_d = S_PLAY;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        S_PLAY: begin
          if (pt1_evt || pt2_evt) begin
            state_d = S_POINT;
            cnt_d   = POINT_CNT;
            if (pt1_evt && !pt2_evt)
              score1_d = (score1_q == 4'hF) ? 4'hF : score1_q + 4'd1;
            else if (pt2_evt && !pt1_evt)
              score2_d = (score2_q == 4'hF) ? 4'hF : score2_q + 4'd1;
          end
        end
        S_POINT: begin
          if (frame_tick) begin
            if (cnt_q <= 8'd1) begin
              cnt_d = 8'd0;
              if (score1_q == WIN_CNT) begin
                state_d  = S_GAMEOVER;
                winner_d = 2'b01;
              end else if (score2_q == WIN_CNT) begin
                state_d  = S_GAMEOVER;
                winner_d = 2'b10;
              end else begin
                state_d    = S_SERVE;
                cnt_d      = SERVE_CNT;
                ball_rst_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      score1_q   <= 4'd0;
      score2_q   <= 4'd0;
      winner_q   <= 2'b00;
      ball_rst_q <= 1'b0;
      ball_en_q  <= 1'b0;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_prev_q <= 1'b0;
      p1_q       <= 1'b0;
      p1_prev_q  <= 1'b0;
      p2_q       <= 1'b0;
      p2_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      winner_q   <= winner_d;
      ball_rst_q <= ball_rst_d;
      ball_en_q  <= ball_en_d;
      btn_s1_q   <= btn_start;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
      p1_q       <= pointPlayer1;
      p1_prev_q  <= p1_q;
      p2_q       <= pointPlayer2;
      p2_prev_q  <= p2_q;
    end
  end

  assign ball_rst    = ball_rst_q;
  assign ball_enable = ball_en_q;
  assign score1      = score1_q;
  assign score2      = score2_q;
  assign winner      = winner_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - Self-checking bench for pong_game_ctrl against a match-level score model.
module tb_pong_game_ctrl;

  localparam int WIN   = 7;
  localparam int SERVE = 60;
  localparam int POINT = 90;
  localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_POINT = 3, ST_OVER = 4;

  logic       clk_in = 1'b0;
  logic       i_rst;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic       btn_start, pointPlayer1, pointPlayer2;
  logic       ball_rst, ball_enable;
  logic [3:0] score1, score2;
  logic [1:0] winner;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int m_s1, m_s2, m_win;

  pong_game_ctrl #(.WIN_SCORE(WIN), .SERVE_FRAMES(SERVE), .POINT_FRAMES(POINT)) dut (
    .clk_in(clk_in), .i_rst(i_rst), .o_x(o_x), .o_y(o_y), .btn_start(btn_start),
    .pointPlayer1(pointPlayer1), .pointPlayer2(pointPlayer2), .ball_rst(ball_rst),
    .ball_enable(ball_enable), .score1(score1), .score2(score2), .winner(winner), .state(state)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int st);
    chk({tag, "_state"}, state, st);
    chk({tag, "_score1"}, score1, m_s1);
    chk({tag, "_score2"}, score2, m_s2);
    chk({tag, "_winner"}, winner, m_win);
  endtask

  task automatic cycle(input bit tick);
    if (tick) begin
      o_x = 10'd639;
      o_y = 9'd479;
    end else begin
      o_x = 10'($urandom_range(0, 639));
      o_y = 9'($urandom_range(0, 478));
    end
    @(negedge clk_in);
  endtask

  task automatic frame();
    repeat ($urandom_range(0, 3)) cycle(1'b0);
    cycle(1'b1);
  endtask

  task automatic start_match();
    btn_start = 1'b1;
    repeat (3) cycle(1'b0);
    m_s1 = 0; m_s2 = 0; m_win = 0;
    chk("start_ball_rst", ball_rst, 1);
    check_outputs("start", ST_SERVE);
    btn_start = 1'b0;
    cycle(1'b0);
    chk("start_ball_rst_pulse", ball_rst, 0);
    chk("start_enable", ball_enable, 0);
  endtask

  task automatic serve_phase();
    for (int i = 1; i <= SERVE; i++) begin
      frame();
      if (i == SERVE - 1) begin
        chk("serve_hold_state", state, ST_SERVE);
        chk("serve_hold_enable", ball_enable, 0);
      end
    end
    chk("serve_exit_state", state, ST_PLAY);
    chk("serve_exit_enable_lag", ball_enable, 0);
    cycle(1'b0);
    chk("play_enable", ball_enable, 1);
  endtask

  task automatic score_point(input bit a, input bit b);
    pointPlayer1 = a;
    pointPlayer2 = b;
    cycle(1'b0);
    cycle(1'b0);
    if (a && !b) m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
    if (b && !a) m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
    check_outputs("point", ST_POINT);
    cycle(1'b0);
    chk("point_enable_fall", ball_enable, 0);
  endtask

  task automatic point_phase();
    int exp_st;
    for (int i = 1; i <= POINT; i++) begin
      frame();
      if (i == POINT - 1) check_outputs("point_hold", ST_POINT);
    end
    if (m_s1 == WIN) m_win = 1;
    else if (m_s2 == WIN) m_win = 2;
    exp_st = (m_win != 0) ? ST_OVER : ST_SERVE;
    check_outputs("point_exit", exp_st);
    chk("point_exit_ball_rst", ball_rst, (m_win == 0) ? 1 : 0);
    pointPlayer1 = 1'b0;
    pointPlayer2 = 1'b0;
    cycle(1'b0);
    chk("point_exit_ball_rst_pulse", ball_rst, 0);
  endtask

  task automatic play_match(input bit p2_must_win);
    int r;
    int n;
    start_match();
    serve_phase();
    n = 0;
    while (m_win == 0 && n < 40) begin
      r = $urandom_range(0, 7);
      if (r == 0) score_point(1'b1, 1'b1);
      else if (p2_must_win) begin
        if (m_s1 < WIN - 1 && r < 3) score_point(1'b1, 1'b0);
        else score_point(1'b0, 1'b1);
      end else begin
        if (r < 4) score_point(1'b1, 1'b0);
        else score_point(1'b0, 1'b1);
      end
      point_phase();
      if (m_win == 0) serve_phase();
      n++;
    end
    chk("match_has_winner", (m_win != 0) ? 1 : 0, 1);
    repeat (3) frame();
    check_outputs("gameover_hold", ST_OVER);
    chk("gameover_enable", ball_enable, 0);
  endtask

  initial begin
    i_rst = 1'b1;
    btn_start = 1'b0;
    pointPlayer1 = 1'b0;
    pointPlayer2 = 1'b0;
    o_x = 10'd0;
    o_y = 9'd0;
    m_s1 = 0; m_s2 = 0; m_win = 0;
    repeat (3) cycle(1'b0);
    check_outputs("reset", ST_IDLE);
    chk("reset_enable", ball_enable, 0);
    chk("reset_ball_rst", ball_rst, 0);
    i_rst = 1'b0;
    repeat (3) frame();
    check_outputs("idle_wait", ST_IDLE);

    // Point edge in IDLE is ignored.
    pointPlayer1 = 1'b1;
    repeat (3) cycle(1'b0);
    check_outputs("idle_point", ST_IDLE);
    pointPlayer1 = 1'b0;
    repeat (3) cycle(1'b0);

    start_match();
    pointPlayer2 = 1'b1;
    repeat (3) cycle(1'b0);
    check_outputs("serve_point_ignored", ST_SERVE);
    pointPlayer2 = 1'b0;
    repeat (2) cycle(1'b0);
    serve_phase();

    score_point(1'b1, 1'b0);
    pointPlayer2 = 1'b1;
    repeat (3) cycle(1'b0);
    check_outputs("pointstate_point_ignored", ST_POINT);
    point_phase();
    serve_phase();

    score_point(1'b1, 1'b1);
    point_phase();
    serve_phase();

    // Restart while in PLAY clears the match.
    start_match();
    serve_phase();

    play_match(1'b0);
    play_match(1'b1);
    chk("p2_win_winner", winner, 2);
    chk("p2_win_score2", score2, WIN);

    start_match();
    serve_phase();
    for (int k = 0; k < 3; k++) begin
      score_point(1'b1, 1'b0);
      point_phase();
      serve_phase();
    end
    chk("pre_reset_score1", score1, 3);
    pointPlayer1 = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    m_s1 = 0; m_s2 = 0; m_win = 0;
    check_outputs("async_reset", ST_IDLE);
    chk("async_reset_enable", ball_enable, 0);
    chk("async_reset_ball_rst", ball_rst, 0);
    @(negedge clk_in);
    repeat (2) cycle(1'b0);
    i_rst = 1'b0;
    repeat (5) frame();
    check_outputs("post_reset_idle", ST_IDLE);

    // A flag held high across reset release and start must not score.
    start_match();
    serve_phase();
    repeat (4) cycle(1'b0);
    check_outputs("held_flag_no_point", ST_PLAY);
    pointPlayer1 = 1'b0;
    repeat (2) cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7: score that ends a match; legal range 1..15.
REQ-002 Parameter SERVE_FRAMES, default 60: frames held in SERVE before the ball is released; legal range 1..255.
REQ-003 Parameter POINT_FRAMES, default 90: frames held frozen after a point; legal range 1..255.
REQ-004 Port clk_in  input  1: single clock; all logic is rising-edge.
REQ-005 Port i_rst  input  1: reset, asynchronous, active-high.
REQ-006 Port o_x  input  10: current pixel column from the VGA timing block.
REQ-007 Port o_y  input  9: current pixel row from the VGA timing block.
REQ-008 Port btn_start  input  1: asynchronous start/restart button, active-high.
REQ-009 Port pointPlayer1  input  1: point flag from the ball block; level, may stay high.
REQ-010 Port pointPlayer2  input  1: point flag from the ball block; level, may stay high.
REQ-011 Port ball_rst  output  1: one-cycle pulse that re-centres the ball and clears its point flags.
REQ-012 Port ball_enable  output  1: high only while ball motion is allowed.
REQ-013 Port score1  output  4: player 1 score.
REQ-014 Port score2  output  4: player 2 score.
REQ-015 Port winner  output  2: 00 none, 01 player 1, 10 player 2.
REQ-016 Port state  output  3: current FSM encoding, for debug.

Function
REQ-017 Frame tick: a one-cycle internal pulse in the cycle where o_x==639 and o_y==479; all frame counters advance only on this tick.
REQ-018 btn_start is passed through a 2-flop synchronizer; a start event is a rising edge of the synchronized signal.
REQ-019 pointPlayer1 and pointPlayer2 are each registered once; a point event is a rising edge of the registered signal.
REQ-020 FSM states and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4.
REQ-021 IDLE -> SERVE on a start event: both scores cleared, winner=00, ball_rst pulsed, frame counter loaded with SERVE_FRAMES.
REQ-022 SERVE: the counter decrements on each frame tick; at zero, go to PLAY; ball_enable=0 throughout SERVE.
REQ-023 PLAY: ball_enable=1; a point event for player N increments scoreN, then go to POINT with the counter loaded with POINT_FRAMES.
REQ-024 PLAY, both point events in the same cycle: neither score changes; go to POINT.
REQ-025 Point events are ignored in every state other than PLAY.
REQ-026 POINT: ball_enable=0; the counter decrements per frame tick; at zero, either condition below applies.
REQ-027 POINT exit when scoreN==WIN_SCORE: go to GAMEOVER and set winner accordingly.
REQ-028 POINT exit otherwise: pulse ball_rst, load SERVE_FRAMES, go to SERVE.
REQ-029 Scores saturate at 15 and never wrap.
REQ-030 GAMEOVER: ball_enable=0; scores and winner are held; a start event behaves as in REQ-021.
REQ-031 A start event in SERVE, PLAY or POINT restarts the match exactly as in REQ-021.
REQ-032 ball_rst is high for exactly one clock per assertion and is registered.
REQ-033 ball_enable is a registered output; it rises 1 clock after entering PLAY and falls 1 clock after leaving it.
REQ-034 Illegal state encodings recover to IDLE on the next clock.

Reset
REQ-035 While i_rst=1, outputs are forced without waiting for a clock: state=IDLE, score1=0, score2=0, winner=00, ball_enable=0, ball_rst=0.
REQ-036 While i_rst=1, internal state is also forced without waiting for a clock: frame counter=0, synchronizer and edge-detect flops=0.
REQ-037 Reset asserted mid-match abandons the match; after release the FSM waits in IDLE for a new start event.
REQ-038 A point flag that is already high at reset release does not produce a point event.

Verification
REQ-039 Start scenario: start pulse from IDLE -> ball_rst high for 1 cycle; SERVE for exactly 60 frame ticks; PLAY with ball_enable=1.
REQ-040 Single point: in PLAY, raise pointPlayer1 and hold it high -> score1=1 exactly once; POINT for 90 ticks; ball_rst pulse; back to SERVE.
REQ-041 Simultaneous point: in PLAY, raise both flags in the same cycle -> scores unchanged; POINT entered.
REQ-042 Win: player 2 scores 7 points -> GAMEOVER, winner=10, score2=7, ball_enable=0; a further start event -> scores 0, SERVE.
REQ-043 Reset mid-match: assert i_rst asynchronously in PLAY with score1=3 -> outputs zero immediately; IDLE persists until a start event.
REQ-044 Point outside PLAY: point edge during SERVE or POINT -> no score change.
